muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit; consumes the 5-bit ALU operation code produced by the ALU decoder and executes the M-extension subset the single-cycle ALU does not. Sits beside the ALU in the execute stage. `busy_o` stalls the pipeline; `done_o` returns the 32-bit result to writeback.

---
 rtl/alu_op_pkg.sv | 53 +++++
 rtl/muldiv_sign_ctrl.sv | 49 ++++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_pkg.sv
// +----------------------------------------------------------------------+
// | alu_op_pkg : ALU op codes shared by the ALU decoder and muldiv_unit,  |
// |              plus the multiply/divide FSM state type.  Rev 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_op_pkg;

  localparam logic [4:0] and_op    = 5'b00000;
  localparam logic [4:0] or_op     = 5'b00001;
  localparam logic [4:0] add_op    = 5'b00010;
  localparam logic [4:0] sub_op    = 5'b00011;
  localparam logic [4:0] xor_op    = 5'b00100;
  localparam logic [4:0] sll_op    = 5'b00101;
  localparam logic [4:0] srl_op    = 5'b00110;
  localparam logic [4:0] sra_op    = 5'b00111;
  localparam logic [4:0] slt_op    = 5'b01000;
  localparam logic [4:0] mulu_op   = 5'b01001;
  localparam logic [4:0] mulhs_op  = 5'b01010;
  localparam logic [4:0] mulhsu_op = 5'b01011;
  localparam logic [4:0] mulhu_op  = 5'b01100;
  localparam logic [4:0] divu_op   = 5'b01101;
  localparam logic [4:0] divs_op   = 5'b01110;
  localparam logic [4:0] remu_op   = 5'b01111;
  localparam logic [4:0] rems_op   = 5'b10000;
  localparam logic [4:0] sltu_op   = 5'b10001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_mul_op(input logic [4:0] op);
    return op inside {mulu_op, mulhs_op, mulhsu_op, mulhu_op};
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op inside {divu_op, divs_op, remu_op, rems_op};
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return op inside {remu_op, rems_op};
  endfunction

  function automatic logic is_sdiv_op(input logic [4:0] op);
    return op inside {divs_op, rems_op};
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sign_ctrl.sv
// +----------------------------------------------------------------------+
// | muldiv_sign_ctrl : operand magnitude/sign extraction and final        |
// |                    negation + half select (combinational). Rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module muldiv_sign_ctrl
  import alu_op_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]        op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   mag_a_o,
  output logic [XLEN-1:0]   mag_b_o,
  output logic              neg_o,
  input  logic [4:0]        res_op_i,
  input  logic              res_neg_i,
  input  logic [2*XLEN-1:0] raw_i,
  output logic [XLEN-1:0]   result_o
);

  logic              w_sa;
  logic              w_sb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_half;

  always_comb begin
    w_sa    = (op_i inside {mulhs_op, mulhsu_op, divs_op, rems_op}) & a_i[XLEN-1];
    w_sb    = (op_i inside {mulhs_op, divs_op, rems_op}) & b_i[XLEN-1];
    mag_a_o = w_sa ? (~a_i + 1'b1) : a_i;
    mag_b_o = w_sb ? (~b_i + 1'b1) : b_i;
    neg_o   = (op_i == rems_op) ? w_sa : (w_sa ^ w_sb);
  end

  // Products negate as a full 64-bit value; quotient/remainder negate per half.
  always_comb begin
    w_prod   = res_neg_i ? (~raw_i + 1'b1) : raw_i;
    w_half   = is_rem_op(res_op_i) ? raw_i[2*XLEN-1:XLEN] : raw_i[XLEN-1:0];
    result_o = res_neg_i ? (~w_half + 1'b1) : w_half;
    if (is_mul_op(res_op_i)) begin
      result_o = (res_op_i == mulu_op) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// +----------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply/divide unit.                   |
// | Option MULDIV_FAST_MUL_EN: single-cycle multiplier path. Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module muldiv_unit
  import alu_op_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [4:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_neg;
  logic [XLEN-1:0]   w_final;
  logic              w_accept;
  logic              w_special;
  logic [XLEN-1:0]   w_preset;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;

  muldiv_sign_ctrl #(.XLEN(XLEN)) u_sign_ctrl (
    .op_i      (alu_op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .mag_a_o   (w_mag_a),
    .mag_b_o   (w_mag_b),
    .neg_o     (w_neg),
    .res_op_i  (op_q),
    .res_neg_i (neg_q),
    .raw_i     (acc_q),
    .result_o  (w_final)
  );

  assign w_accept  = ((state_q == IDLE) || (state_q == DONE)) && start_i &&
                     (is_mul_op(alu_op_i) || is_div_op(alu_op_i));
  assign w_special = is_div_op(alu_op_i) &&
                     ((b_i == '0) ||
                      (is_sdiv_op(alu_op_i) && (a_i == INT_MIN) && (b_i == '1)));
  assign w_preset  = (b_i == '0) ? (is_rem_op(alu_op_i) ? a_i : '1)
                                 : (is_rem_op(alu_op_i) ? '0 : INT_MIN);

  // acc holds {high/remainder, low/quotient}; both start with the low half = |a|.
  assign w_mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
  assign w_div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, divisor_q};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    op_d      = op_q;
    neg_d     = neg_q;
    result_d  = result_q;
    busy_o    = (state_q == CALC) || (state_q == SIGN);
    done_o    = (state_q == DONE);

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (w_accept) begin
          op_d      = alu_op_i;
          divisor_d = w_mag_b;
          neg_d     = w_neg;
          acc_d     = {{XLEN{1'b0}}, w_mag_a};
          cnt_d     = 5'd31;
          state_d   = CALC;
          if (w_special) begin
            acc_d   = {w_preset, w_preset};
            neg_d   = 1'b0;
            cnt_d   = 5'd0;
            state_d = SIGN;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (is_mul_op(alu_op_i)) begin
            acc_d   = w_fast_prod;
            cnt_d   = 5'd0;
            state_d = SIGN;
          end
`endif
        end
      end
      CALC: begin
        if (is_mul_op(op_q)) begin
          acc_d = {w_mul_sum, acc_q[XLEN-1:1]};
        end else begin
          acc_d = {(w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0]),
                   acc_q[XLEN-2:0], ~w_div_diff[XLEN]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        result_d = w_final;
        state_d  = DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= '0;
      divisor_q <= '0;
      op_q      <= 5'd0;
      neg_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// +----------------------------------------------------------------------+
// | tb_muldiv_unit : self-checking bench for muldiv_unit against an       |
// |                  arithmetic reference model.  Rev 1.0                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_unit;
  import alu_op_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [4:0]  alu_op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] result_o;
  logic        busy_o;
  logic        done_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = 32'd0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .alu_op_i (alu_op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .result_o (result_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    int              ia;
    int              ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    p  = 64'd0;
    case (op)
      mulu_op:   begin p = ua * ub;          return p[31:0];  end
      mulhs_op:  begin p = sa * sb;          return p[63:32]; end
      mulhsu_op: begin p = sa * longint'(ub); return p[63:32]; end
      mulhu_op:  begin p = ua * ub;          return p[63:32]; end
      divu_op:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      remu_op:   return (b == 0) ? a : a % b;
      divs_op: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      rems_op: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit is_div = (op == divu_op) || (op == divs_op) || (op == remu_op) || (op == rems_op);
    bit is_sgn = (op == divs_op) || (op == rems_op);
    if (is_div && (b == 0 || (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div) return 2;
`endif
    return 34;
  endfunction

  // Drives a request in the current cycle and returns in the cycle done_o is seen.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit interfere);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    int          busy_cnt;
    bit          held;
    exp_res  = ref_result(op, a, b);
    exp_lat  = ref_latency(op, a, b);
    lat      = 0;
    busy_cnt = 0;
    held     = 1'b1;
    start_i  = 1'b1;
    alu_op_i = op;
    a_i      = a;
    b_i      = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      if (done_o) begin
        lat = k;
      end else begin
        if (busy_o) busy_cnt++;
        if (result_o !== last_res) held = 1'b0;
      end
      if (interfere && k == 5) begin
        start_i  = 1'b1;
        alu_op_i = divu_op;
        a_i      = $urandom;
        b_i      = $urandom;
      end
      if (interfere && k == 6) start_i = 1'b0;
    end
    check_eq({tag, " result"}, result_o, exp_res);
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
    check_eq({tag, " result_held"}, {31'd0, held}, 32'd1);
    last_res = exp_res;
  endtask

  logic [4:0] ops [8] = '{mulu_op, mulhs_op, mulhsu_op, mulhu_op,
                          divu_op, divs_op, remu_op, rems_op};

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          saw_busy;
    bit          saw_done;
    rst      = 1'b1;
    start_i  = 1'b0;
    alu_op_i = 5'd0;
    a_i      = 32'd0;
    b_i      = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", {31'd0, busy_o}, 32'd0);
    check_eq("reset done", {31'd0, done_o}, 32'd0);
    check_eq("reset result", result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mulu 7*6",          mulu_op,   32'd7,         32'd6,         1'b0);
    @(negedge clk);
    check_eq("done pulse width", {31'd0, done_o}, 32'd0);
    run_op("mulhs",             mulhs_op,  32'h8000_0000, 32'd2,         1'b0);
    run_op("mulhu",             mulhu_op,  32'h8000_0000, 32'd2,         1'b0);
    run_op("mulhsu",            mulhsu_op, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("divs -7/2",         divs_op,   32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op("rems -7%2",         rems_op,   32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op("remu 7%2",          remu_op,   32'd7,         32'd2,         1'b0);
    run_op("divu 100/7",        divu_op,   32'd100,       32'd7,         1'b0);
    run_op("divu by 0",         divu_op,   32'd5,         32'd0,         1'b0);
    run_op("remu by 0",         remu_op,   32'd5,         32'd0,         1'b0);
    run_op("divs overflow",     divs_op,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rems overflow",     rems_op,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("start during CALC", mulu_op,   32'd1234,      32'd5678,      1'b1);

    // Back-to-back: second request issued in the DONE cycle of the first.
    run_op("b2b first",  mulu_op, 32'd7, 32'd6, 1'b0);
    run_op("b2b second", divu_op, 32'd9, 32'd3, 1'b0);

    // Illegal code must not start anything.
    @(negedge clk);
    start_i  = 1'b1;
    alu_op_i = add_op;
    a_i      = 32'd3;
    b_i      = 32'd4;
    saw_busy = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (busy_o) saw_busy = 1'b1;
      if (done_o) saw_done = 1'b1;
    end
    check_eq("add op busy", {31'd0, saw_busy}, 32'd0);
    check_eq("add op done", {31'd0, saw_done}, 32'd0);
    check_eq("add op result", result_o, last_res);

    // Reset ten cycles into CALC.
    start_i  = 1'b1;
    alu_op_i = divu_op;
    a_i      = 32'd1000;
    b_i      = 32'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre-reset busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid-CALC reset busy", {31'd0, busy_o}, 32'd0);
    check_eq("mid-CALC reset done", {31'd0, done_o}, 32'd0);
    check_eq("mid-CALC reset result", result_o, 32'd0);
    last_res = 32'd0;
    @(negedge clk);
    check_eq("post-reset idle busy", {31'd0, busy_o}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = $urandom_range(1, 15);
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op("random", ops[$urandom_range(0, 7)], ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
